// File: rtl/mux_stream_n.sv
`default_nettype none
// ============================================================================
// mux_stream_n : N-channel registered stream mux, fixed-select or round-robin
// Revision     : 1.0
// ============================================================================
module mux_stream_n #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [W-1:0]      out_data,
  output logic [SW-1:0]     out_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_err
);

  generate
    if ((N < 2) || (N > 16) || ((1 << SW) < N)) begin : g_bad_params
      $error("mux_stream_n: need 2 <= N <= 16 and 2**SW >= N");
    end
  endgenerate

  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_chan;
  logic          r_out_valid;
  logic          r_sel_err;
  logic [SW-1:0] r_ptr;

  logic          w_load_en;
  logic          w_sel_ok;
  logic          w_fix_vld;
  logic          w_rr_found;
  logic [SW-1:0] w_rr_g;
  logic [SW-1:0] w_ptr_nxt;
  logic          w_gnt_vld;
  logic [SW-1:0] w_gnt;
  logic [W-1:0]  w_gnt_data;
  int            w_idx;

  assign w_load_en = !r_out_valid || out_ready;
  assign w_sel_ok  = int'(sel) < N;

  always_comb begin
    w_fix_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_sel_ok && (sel == i[SW-1:0]) && in_valid[i]) w_fix_vld = 1'b1;
    end
  end

  // Rotating search starting at r_ptr; r_ptr is always < N, so one subtract wraps.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_g     = '0;
    w_idx      = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_rr_found && in_valid[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_g     = w_idx[SW-1:0];
      end
    end
  end

  assign w_ptr_nxt = (int'(w_rr_g) + 1 >= N) ? '0 : w_rr_g + SW'(1);
  assign w_gnt_vld = mode ? w_rr_found : w_fix_vld;
  assign w_gnt     = mode ? w_rr_g : sel;

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == i[SW-1:0]) w_gnt_data = in_data[i*W +: W];
    end
  end

  // Ready follows the would-be grant channel, not in_ready itself, so no loop.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (rst_n && w_load_en) begin
        if (mode) begin
          if (w_rr_found && (w_rr_g == i[SW-1:0])) in_ready[i] = 1'b1;
        end else begin
          if (w_sel_ok && (sel == i[SW-1:0])) in_ready[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
      r_ptr       <= '0;
    end else begin
      r_sel_err <= !mode && !w_sel_ok;
      if (w_load_en) begin
        if (w_gnt_vld) begin
          r_out_data  <= w_gnt_data;
          r_out_chan  <= w_gnt;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
      if (mode && w_rr_found && w_load_en) r_ptr <= w_ptr_nxt;
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;
  assign sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_stream_n.sv
`default_nettype none
// ============================================================================
// tb_mux_stream_n : directed bench for mux_stream_n (N=4 and N=3 instances)
// Revision        : 1.0
// ============================================================================
module tb_mux_stream_n;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  in_ready4;
  logic [7:0]  out_data4;
  logic [1:0]  out_chan4;
  logic        out_valid4;
  logic        sel_err4;

  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        sel_err3;

  int n_cmp;
  int n_bad;

  mux_stream_n #(.W(8), .N(4), .SW(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
    .out_data(out_data4), .out_chan(out_chan4), .out_valid(out_valid4),
    .out_ready(out_ready), .sel_err(sel_err4)
  );

  mux_stream_n #(.W(8), .N(3), .SW(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data[23:0]), .in_valid(in_valid[2:0]), .in_ready(in_ready3),
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(out_ready), .sel_err(sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rr_exp [6];
    logic [1:0] alt_exp [4];
    rr_exp  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    alt_exp = '{2'd3, 2'd1, 2'd3, 2'd1};
    n_cmp = 0;
    n_bad = 0;

    // Reset with every channel valid
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = 32'h4433_2211;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid4, 0);
    check("rst_out_data",  out_data4,  0);
    check("rst_out_chan",  out_chan4,  0);
    check("rst_sel_err",   sel_err4,   0);
    check("rst_in_ready",  in_ready4,  0);
    rst_n = 1'b1;
    #1;
    check("fix_ready_sel0", in_ready4, 4'b0001);
    tick();
    check("rel_out_valid", out_valid4, 1);
    check("fix_data_0",    out_data4,  8'h11);
    check("fix_chan_0",    out_chan4,  0);

    // Fixed-select sweep
    for (int s = 1; s < 4; s++) begin
      sel = s[1:0];
      tick();
      check($sformatf("fix_data_%0d", s), out_data4, (s + 1) * 8'h11);
      check($sformatf("fix_chan_%0d", s), out_chan4, s);
    end

    // Backpressure
    sel     = 2'd0;
    in_data = 32'h4433_22A5;
    tick();
    check("bp_load", out_data4, 8'hA5);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_data = 32'h1020_3040 + c;
      sel     = c[1:0];
      #1;
      check($sformatf("bp_ready_%0d", c), in_ready4, 0);
      tick();
      check($sformatf("bp_data_%0d", c),  out_data4,  8'hA5);
      check($sformatf("bp_valid_%0d", c), out_valid4, 1);
    end
    in_data   = 32'h4433_2211;
    sel       = 2'd1;
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready4, 4'b0010);
    tick();
    check("bp_next_data",  out_data4,  8'h22);
    check("bp_next_chan",  out_chan4,  1);
    check("bp_next_valid", out_valid4, 1);

    // Round-robin fairness; pointer is still 0 after fixed mode
    mode = 1'b1;
    #1;
    check("rr_ready_first", in_ready4, 4'b0001);
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("rr_chan_%0d", c), out_chan4, rr_exp[c]);
    end
    in_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rr_alt_chan_%0d", c), out_chan4, alt_exp[c]);
      check($sformatf("rr_alt_data_%0d", c), out_data4, (alt_exp[c] + 1) * 8'h11);
    end

    // Reset pulse between edges with ptr=2 and a held output
    check("mid_valid_before", out_valid4, 1);
    rst_n = 1'b0;
    #1;
    check("mid_valid_async", out_valid4, 0);
    check("mid_ready_low",   in_ready4,  0);
    in_valid = 4'hF;
    #1;
    rst_n = 1'b1;
    tick();
    check("mid_first_chan", out_chan4, 0);
    check("mid_first_data", out_data4, 8'h11);
    check("n3_first_chan",  out_chan3, 0);

    // N=3 round-robin wraps from 2 back to 0
    tick();
    check("n3_rr_1", out_chan3, 1);
    tick();
    check("n3_rr_2", out_chan3, 2);
    tick();
    check("n3_rr_wrap", out_chan3, 0);
    check("n4_rr_3",    out_chan4, 3);

    // Out-of-range select on N=3
    mode = 1'b0;
    sel  = 2'd3;
    #1;
    check("n3_oor_ready", in_ready3, 0);
    tick();
    check("n3_oor_err",   sel_err3,   1);
    check("n3_oor_drain", out_valid3, 0);
    check("n4_sel3_err",  sel_err4,   0);
    check("n4_sel3_data", out_data4,  8'h44);
    sel = 2'd2;
    tick();
    check("n3_sel2_err",   sel_err3,   0);
    check("n3_sel2_data",  out_data3,  8'h33);
    check("n3_sel2_chan",  out_chan3,  2);
    check("n3_sel2_valid", out_valid3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
